// File: rtl/multicycle_control.sv
// Multicycle datapath controller: fetch / decode / memory / execute / branch sequencing.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic [1:0]  alu_operation,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_source,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;

  state_t state_q, state_d;
  logic   is_store_q;
  logic   illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Opcode bit 5 separates sd from ld; keep it so MEM_ADDR need not see the IR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  is_store_q <= 1'b0;
    else if (state_q == DECODE) is_store_q <= opcode[5];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                illegal_q <= 1'b0;
    else if (state_q == TRAP) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q | (state_q == TRAP);
  assign state   = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] count_q;
  logic        retire;

  // Only completed instructions count; trap exits do not.
  assign retire = (state_d == FETCH) &&
                  ((state_q == MEM_WB) || (state_q == MEM_WRITE) ||
                   (state_q == R_WB)   || (state_q == BRANCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count_q <= 32'd0;
    else if (retire) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

  always_comb begin
    state_d       = FETCH;
    alu_operation = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_LD, OP_SD: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          default:      state_d = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_store_q ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        state_d   = mem_ready ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        alu_src_a     = 1'b1;
        alu_operation = 2'b10;
        state_d       = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // FETCH is the reset state but must not start a memory read while held in reset.
    if (reset) begin
      alu_operation = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
    end
  end

endmodule
